pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with elastic buffering, the general replacement for fixed inter-stage latches (EX/MEM, MEM/WB). Holds up to DEPTH in-order entries, each a control field plus a data field, behind valid/ready handshakes on both sides. Adds stall absorption, synchronous flush with bubble insertion, and a flush-drop statistics counter. Sits between two pipeline stages; upstream pushes, downstream pops.

---
 rtl/pipe_stage_buf.sv | 87 ++++++++
 tb/tb_pipe_stage_buf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: a DEPTH-entry in-order buffer of {ctrl, data}
// with valid/ready handshakes, synchronous flush, and a saturating flush-drop counter.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 6,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CTRL_W-1:0] ctrl_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [CNT_W-1:0]  count_q;
    logic [15:0]       drop_q;

    logic              push;
    logic              pop;
    logic [16:0]       drop_sum;
    logic [15:0]       drop_next;

    // Handshake decode: in_ready depends on registered occupancy only, so a full
    // buffer never accepts even when the head is being consumed this cycle.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_ctrl  = out_valid ? ctrl_mem[rp] : '0;
    assign out_data  = out_valid ? data_mem[rp] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

    // One extra bit catches overflow so the statistic clamps instead of wrapping.
    assign drop_sum  = {1'b0, drop_q} + 17'(count_q);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
            drop_q  <= drop_next;
        end else begin
            if (push) begin
                ctrl_mem[wp] <= in_ctrl;
                data_mem[wp] <= in_data;
                wp           <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench: a DEPTH=2 instance for handshake/flush/reset behaviour
// and a DEPTH=64 instance to drive the drop counter into saturation quickly.
module tb_pipe_stage_buf;

    logic        clk;
    logic        rst_n;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_ctrl;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_ctrl;
    logic [63:0] out_data;
    logic [1:0]  count;
    logic [15:0] drop_cnt;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [5:0]  s_in_ctrl;
    logic [63:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [5:0]  s_out_ctrl;
    logic [63:0] s_out_data;
    logic [6:0]  s_count;
    logic [15:0] s_drop_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(6), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .count(count), .drop_cnt(drop_cnt)
    );

    pipe_stage_buf #(.DATA_W(64), .CTRL_W(6), .DEPTH(64)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .count(s_count), .drop_cnt(s_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] c, input logic [63:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic fillSat(input int n);
        s_in_valid = 1'b1;
        repeat (n) tick();
        s_in_valid = 1'b0;
    endtask

    task automatic flushSat();
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b0, 1'b0);
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = 6'h15; s_in_data = 64'h0; s_out_ready = 1'b0;

        #3;
        checkOutput("por_in_ready", 64'(in_ready), 64'h1);
        checkOutput("por_out_valid", 64'(out_valid), 64'h0);
        checkOutput("por_count", 64'(count), 64'h0);
        #9 rst_n = 1'b1;

        // Pass-through with out_ready high
        applyStimulus(1'b1, 6'h21, 64'h1111, 1'b1, 1'b0);
        tick();
        checkOutput("pt1_data", out_data, 64'h1111);
        checkOutput("pt1_ctrl", 64'(out_ctrl), 64'h21);
        checkOutput("pt1_count", 64'(count), 64'h1);
        applyStimulus(1'b1, 6'h21, 64'h2222, 1'b1, 1'b0);
        tick();
        checkOutput("pt2_data", out_data, 64'h2222);
        checkOutput("pt2_count", 64'(count), 64'h1);
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pt_drain_valid", 64'(out_valid), 64'h0);
        checkOutput("pt_drain_ctrl", 64'(out_ctrl), 64'h0);
        checkOutput("pt_drain_data", out_data, 64'h0);

        // Empty with out_ready high: nothing happens
        tick();
        checkOutput("empty_count", 64'(count), 64'h0);
        checkOutput("empty_data", out_data, 64'h0);

        // Backpressure
        applyStimulus(1'b1, 6'h01, 64'h3333, 1'b0, 1'b0);
        tick();
        checkOutput("bp1_count", 64'(count), 64'h1);
        checkOutput("bp1_in_ready", 64'(in_ready), 64'h1);
        applyStimulus(1'b1, 6'h02, 64'h4444, 1'b0, 1'b0);
        tick();
        checkOutput("bp2_count", 64'(count), 64'h2);
        checkOutput("bp2_in_ready", 64'(in_ready), 64'h0);
        applyStimulus(1'b1, 6'h03, 64'h5555, 1'b0, 1'b0);
        tick();
        checkOutput("bp3_count", 64'(count), 64'h2);
        checkOutput("bp3_head", out_data, 64'h3333);
        applyStimulus(1'b1, 6'h03, 64'h5555, 1'b1, 1'b0);
        tick();
        checkOutput("bp4_count", 64'(count), 64'h1);
        checkOutput("bp4_head", out_data, 64'h4444);
        checkOutput("bp4_head_ctrl", 64'(out_ctrl), 64'h02);
        checkOutput("bp4_in_ready", 64'(in_ready), 64'h1);
        tick();
        checkOutput("bp5_count", 64'(count), 64'h1);
        checkOutput("bp5_head", out_data, 64'h5555);
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp6_count", 64'(count), 64'h0);

        // Simultaneous push/pop at count=1, pointers wrapping repeatedly
        applyStimulus(1'b1, 6'h10, 64'hA000, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b1, 6'(6'h10 + i), 64'hA000 + 64'(i), 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("wrap%0d_count", i), 64'(count), 64'h1);
            checkOutput($sformatf("wrap%0d_data", i), out_data, 64'hA000 + 64'(i));
            checkOutput($sformatf("wrap%0d_ctrl", i), 64'(out_ctrl), 64'(6'h10 + i));
        end
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_drain_count", 64'(count), 64'h0);

        // Flush at count=2 with a new entry presented
        applyStimulus(1'b1, 6'h04, 64'h6666, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 6'h05, 64'h7777, 1'b0, 1'b0);
        tick();
        checkOutput("fl_pre_count", 64'(count), 64'h2);
        applyStimulus(1'b1, 6'h06, 64'h8888, 1'b0, 1'b1);
        tick();
        checkOutput("fl_count", 64'(count), 64'h0);
        checkOutput("fl_out_valid", 64'(out_valid), 64'h0);
        checkOutput("fl_out_ctrl", 64'(out_ctrl), 64'h0);
        checkOutput("fl_out_data", out_data, 64'h0);
        checkOutput("fl_in_ready", 64'(in_ready), 64'h1);
        checkOutput("fl_drop", 64'(drop_cnt), 64'h2);
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b0, 1'b0);
        tick();
        checkOutput("fl_not_stored", 64'(count), 64'h0);

        // Asynchronous reset mid-run with count=2
        applyStimulus(1'b1, 6'h07, 64'h9999, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 6'h08, 64'hAAAA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b0, 1'b0);
        checkOutput("rst_pre_count", 64'(count), 64'h2);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'h0);
        checkOutput("rst_out_data", out_data, 64'h0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'h1);
        checkOutput("rst_count", 64'(count), 64'h0);
        checkOutput("rst_drop", 64'(drop_cnt), 64'h0);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 6'h09, 64'hBBBB, 1'b0, 1'b0);
        tick();
        checkOutput("post_rst_data", out_data, 64'hBBBB);
        checkOutput("post_rst_count", 64'(count), 64'h1);
        applyStimulus(1'b0, 6'h00, 64'h0, 1'b0, 1'b0);

        // Drop counter saturation on the deep instance
        for (int i = 0; i < 1023; i++) begin
            fillSat(64);
            if (i == 0) begin
                checkOutput("sat_full_count", 64'(s_count), 64'd64);
                checkOutput("sat_full_in_ready", 64'(s_in_ready), 64'h0);
            end
            flushSat();
            if (i == 0) checkOutput("sat_first_drop", 64'(s_drop_cnt), 64'd64);
        end
        checkOutput("sat_bulk_drop", 64'(s_drop_cnt), 64'hFFC0);
        fillSat(62);
        flushSat();
        checkOutput("sat_fffe", 64'(s_drop_cnt), 64'hFFFE);
        fillSat(2);
        flushSat();
        checkOutput("sat_ffff", 64'(s_drop_cnt), 64'hFFFF);
        checkOutput("sat_count", 64'(s_count), 64'h0);
        fillSat(2);
        flushSat();
        checkOutput("sat_hold", 64'(s_drop_cnt), 64'hFFFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
